sfu_bank: RTL and testbench
===========================

# sfu_bank

Multi-channel special-function unit that accumulates a fixed number of partial-sum beats per column, optionally applies ReLU, and presents the finished vector on a valid/ready output. It sits between the PE array output FIFO and the output SRAM write port, replacing per-column single-lane accumulators with one sequenced block covering all columns.

## Interface
- psum_bw, 16, width of one channel's partial sum (signed two's complement)
- col, 8, number of parallel channels
- cnt_bw, 8, width of the accumulation-length field
- clk  input  1  clock, all state updates on rising edge
- reset  input  1  reset, synchronous, active-high; clock clk
- start  input  1  begin a job; sampled only in IDLE
- acc_len  input  cnt_bw  number of input beats to accumulate; sampled with start
- relu_en  input  1  apply ReLU before output; sampled with start
- in_valid  input  1  input beat present
- in  input  col*psum_bw  channel c at bits [c*psum_bw +: psum_bw]
- out_valid  output  1  finished vector available
- out_ready  input  1  consumer accepts vector
- out  output  col*psum_bw  accumulated (and optionally rectified) vector, same packing as in
- busy  output  1  high whenever state is not IDLE

## Operation
- FSM states: IDLE, ACC, RELU, OUT.
- IDLE: start=1 -> latch acc_len into beat counter target, latch relu_en, clear all col accumulators to 0, go ACC. start=0 -> stay.
- ACC: each cycle with in_valid=1, every channel adds its in slice to its accumulator and the beat counter increments. When the accepted beat is number acc_len, go RELU. in_valid=0 -> hold.
- acc_len=0: ACC performs no accumulation and moves to RELU on its first cycle; output is all zeros.
- RELU: if latched relu_en=1, each negative accumulator becomes 0; non-negative unchanged. relu_en=0 -> unchanged. Always one cycle, then OUT.
- OUT: out_valid=1. Transfer when out_valid & out_ready; next state IDLE.
- out is driven directly from the accumulators; it holds its value after the transfer until the next start clears it.
- start outside IDLE ignored; in_valid outside ACC ignored (beat dropped, no counter change).
- Reset at any point: state IDLE, accumulators 0, counter 0, latched relu_en 0.
- Reset values: out_valid=0, busy=0, out=0.

## Timing
- start at cycle t -> busy=1 and accumulators zero from t+1; in beats accepted from t+1.
- Final (acc_len-th) beat accepted at cycle k -> RELU at k+1 -> out_valid=1 at k+2.
- Minimum job: acc_len=N with in_valid held high -> out_valid at t+N+2 (acc_len=0: t+2... ACC at t+1, RELU t+2, out_valid t+3).
- out_ready may be low indefinitely; out and out_valid stable while waiting.
- Transfer at cycle m -> out_valid=0, busy=0 at m+1; a start at m+1 is accepted.
- out_ready ignored when out_valid=0.

## Configuration
- SFU_SAT_EN defined: each channel add saturates to signed psum_bw range (max 2^(psum_bw-1)-1, min -2^(psum_bw-1)); a saturated accumulator stays clamped while further beats push the same direction and moves normally otherwise.
- SFU_SAT_EN undefined: adds wrap modulo 2^psum_bw, matching the legacy single-lane accumulator.

## Test plan
- col=4, psum_bw=16: start, acc_len=3, relu_en=0, beats ch0 {5,-2,4}, ch1 {-10,1,1} -> out ch0=7, ch1=-8, out_valid exactly 5 cycles after start with in_valid held high.
- Same stimulus with relu_en=1 -> ch0=7, ch1=0; out_valid held 4 cycles with out_ready=0, value stable, drops one cycle after out_ready=1.
- acc_len=0, start -> out all zeros, out_valid at start+3; in_valid beats during job ignored.
- Two beats of ch0=30000 each: with SFU_SAT_EN -> 32767; without -> -5536.
- Reset asserted in ACC after 1 of 4 beats -> next cycle busy=0, out_valid=0, out=0; new start accumulates from 0.
- start pulsed during ACC and OUT -> no effect on counter or out; in_valid pulses in IDLE/RELU/OUT -> accumulators unchanged.

Source files
------------

// File: rtl/sfu_bank_if.sv
// sfu_bank job/stream bundle: job control, input beats, output vector.
// master drives jobs and beats; slave is the sfu_bank side.
interface sfu_bank_if #(
    parameter int PSUM_BW = 16,
    parameter int COL     = 8,
    parameter int CNT_BW  = 8
);
    logic                   start;
    logic [CNT_BW-1:0]      acc_len;
    logic                   relu_en;
    logic                   in_valid;
    logic [COL*PSUM_BW-1:0] in;
    logic                   out_valid;
    logic                   out_ready;
    logic [COL*PSUM_BW-1:0] out;
    logic                   busy;

    modport master (
        output start, acc_len, relu_en, in_valid, in, out_ready,
        input  out_valid, out, busy
    );

    modport slave (
        input  start, acc_len, relu_en, in_valid, in, out_ready,
        output out_valid, out, busy
    );
endinterface

// File: rtl/sfu_bank.sv
// Multi-column partial-sum accumulator with optional ReLU and valid/ready output.
// Define SFU_SAT_EN for saturating adds; default wraps modulo 2^PSUM_BW.
module sfu_bank #(
    parameter int PSUM_BW = 16,
    parameter int COL     = 8,
    parameter int CNT_BW  = 8
) (
    input logic       clk,
    input logic       reset,
    sfu_bank_if.slave bus
);
    typedef enum logic [1:0] {IDLE, ACC, RELU, OUT} state_t;

    state_t                        state_q, state_d;
    logic [CNT_BW-1:0]             len_q, cnt_q, cnt_nx;
    logic                          relu_q;
    logic [COL-1:0][PSUM_BW-1:0]   acc_q;
    logic                          clr, add, relu_do;

    function automatic logic [PSUM_BW-1:0] add_ch(
        input logic [PSUM_BW-1:0] a,
        input logic [PSUM_BW-1:0] b
    );
`ifdef SFU_SAT_EN
        logic [PSUM_BW:0] s;
        s = {a[PSUM_BW-1], a} + {b[PSUM_BW-1], b};
        if (s[PSUM_BW] != s[PSUM_BW-1])
            add_ch = s[PSUM_BW] ? {1'b1, {(PSUM_BW-1){1'b0}}}
                                : {1'b0, {(PSUM_BW-1){1'b1}}};
        else
            add_ch = s[PSUM_BW-1:0];
`else
        add_ch = a + b;
`endif
    endfunction

    assign cnt_nx = cnt_q + CNT_BW'(1);

    always_comb begin
        state_d = state_q;
        clr     = 1'b0;
        add     = 1'b0;
        relu_do = 1'b0;
        unique case (state_q)
            IDLE: if (bus.start) begin
                clr     = 1'b1;
                state_d = ACC;
            end
            ACC: begin
                if (len_q == '0) begin
                    state_d = RELU;
                end else if (bus.in_valid) begin
                    add = 1'b1;
                    if (cnt_nx == len_q) state_d = RELU;
                end
            end
            RELU: begin
                relu_do = relu_q;
                state_d = OUT;
            end
            OUT: if (bus.out_ready) state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            len_q   <= '0;
            cnt_q   <= '0;
            relu_q  <= 1'b0;
            acc_q   <= '0;
        end else begin
            state_q <= state_d;
            if (clr) begin
                len_q  <= bus.acc_len;
                relu_q <= bus.relu_en;
                cnt_q  <= '0;
                acc_q  <= '0;
            end
            if (add) begin
                cnt_q <= cnt_nx;
                for (int c = 0; c < COL; c++)
                    acc_q[c] <= add_ch(acc_q[c], bus.in[c*PSUM_BW +: PSUM_BW]);
            end
            // rectify in place so out stays a plain view of the accumulators
            if (relu_do) begin
                for (int c = 0; c < COL; c++)
                    if (acc_q[c][PSUM_BW-1]) acc_q[c] <= '0;
            end
        end
    end

    assign bus.out_valid = (state_q == OUT);
    assign bus.busy      = (state_q != IDLE);
    assign bus.out       = acc_q;
endmodule

// File: tb/tb_sfu_bank.sv
// Scoreboard bench for sfu_bank with COL=4, PSUM_BW=16.
// Expected vectors are queued at issue time and popped on each output transfer.
module tb_sfu_bank;
    logic clk = 1'b0;
    logic reset = 1'b1;
    int   pass_cnt = 0;
    int   total_cnt = 0;
    int   cyc = 0;
    int   t0 = 0;
    logic [63:0] sb[$];

    sfu_bank_if #(.PSUM_BW(16), .COL(4), .CNT_BW(8)) bus ();

    sfu_bank #(.PSUM_BW(16), .COL(4), .CNT_BW(8)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    function automatic logic [63:0] v4(input int a, input int b, input int c, input int d);
        return {d[15:0], c[15:0], b[15:0], a[15:0]};
    endfunction

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %h expected %h", nm, act, exp);
    endtask

    always @(negedge clk) begin
        if (!reset && bus.out_valid && bus.out_ready) begin
            if (sb.size() == 0) begin
                total_cnt++;
                $display("FAIL sb_unexpected: got %h expected no transfer", bus.out);
            end else begin
                check("sb_out", bus.out, sb.pop_front());
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_job(input int len, input logic relu);
        bus.start   = 1'b1;
        bus.acc_len = len[7:0];
        bus.relu_en = relu;
        tick();
        t0 = cyc;
        bus.start = 1'b0;
    endtask

    task automatic beat(input logic [63:0] v);
        bus.in_valid = 1'b1;
        bus.in       = v;
        tick();
        bus.in_valid = 1'b0;
    endtask

    task automatic wait_valid(input string nm, input int explat);
        int n = 0;
        int lat;
        while (!bus.out_valid && n < 50) begin
            tick();
            n++;
        end
        lat = bus.out_valid ? (cyc - t0 + 1) : -1;
        check({nm, "_lat"}, 64'(lat), 64'(explat));
    endtask

    logic [63:0] e1, e2, e6, es;

    initial begin
        bus.start     = 1'b0;
        bus.acc_len   = '0;
        bus.relu_en   = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in        = '0;
        bus.out_ready = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        check("rst_out_valid", 64'(bus.out_valid), 64'(0));
        check("rst_busy", 64'(bus.busy), 64'(0));
        check("rst_out", bus.out, 64'(0));

        // plain accumulate, back-to-back beats
        e1 = v4(7, -8, 250, -3);
        sb.push_back(e1);
        start_job(3, 1'b0);
        check("busy_after_start", 64'(bus.busy), 64'(1));
        check("acc_cleared", bus.out, 64'(0));
        beat(v4(5, -10, 100, -1));
        beat(v4(-2, 1, 200, -1));
        beat(v4(4, 1, -50, -1));
        wait_valid("job1", 5);
        tick();

        // relu with backpressure
        e2 = v4(7, 0, 250, 0);
        sb.push_back(e2);
        bus.out_ready = 1'b0;
        start_job(3, 1'b1);
        beat(v4(5, -10, 100, -1));
        beat(v4(-2, 1, 200, -1));
        beat(v4(4, 1, -50, -1));
        wait_valid("job2", 5);
        for (int i = 0; i < 4; i++) begin
            check("hold_valid", 64'(bus.out_valid), 64'(1));
            check("hold_out", bus.out, e2);
            tick();
        end
        bus.out_ready = 1'b1;
        tick();
        check("drop_valid", 64'(bus.out_valid), 64'(0));
        check("drop_busy", 64'(bus.busy), 64'(0));
        check("out_held", bus.out, e2);

        // zero-length job, input beats must be ignored
        sb.push_back(64'(0));
        bus.in_valid = 1'b1;
        bus.in       = v4(99, -99, 7, -7);
        start_job(0, 1'b0);
        bus.in_valid = 1'b1;
        wait_valid("len0", 3);
        check("len0_out", bus.out, 64'(0));
        bus.in_valid = 1'b0;
        tick();

        // overflow behaviour
`ifdef SFU_SAT_EN
        es = v4(32767, -32768, 32667, 6);
`else
        es = v4(-5536, -24464, -5636, 6);
`endif
        sb.push_back(es);
        start_job(3, 1'b0);
        beat(v4(30000, -30000, 30000, 1));
        beat(v4(30000, -30000, 30000, 2));
        beat(v4(0, -30000, -100, 3));
        wait_valid("sat", 5);
        tick();

        // reset mid-accumulation
        start_job(4, 1'b1);
        beat(v4(1000, -1000, 500, 42));
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("midrst_busy", 64'(bus.busy), 64'(0));
        check("midrst_valid", 64'(bus.out_valid), 64'(0));
        check("midrst_out", bus.out, 64'(0));
        sb.push_back(v4(0, 3, 2, 5));
        start_job(2, 1'b0);
        beat(v4(1, 2, 3, 4));
        beat(v4(-1, 1, -1, 1));
        wait_valid("postrst", 4);
        tick();

        // ignored start / in_valid outside their states
        e6 = v4(15, -15, -1, 7);
        sb.push_back(e6);
        bus.out_ready = 1'b0;
        start_job(2, 1'b0);
        beat(v4(10, -20, 3, 0));
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        beat(v4(5, 5, -4, 7));
        bus.in_valid = 1'b1;
        bus.in       = v4(1000, 1000, 1000, 1000);
        tick();
        bus.start = 1'b1;
        tick();
        bus.start    = 1'b0;
        bus.in_valid = 1'b0;
        check("ign_valid", 64'(bus.out_valid), 64'(1));
        check("ign_out", bus.out, e6);
        bus.out_ready = 1'b1;
        tick();
        check("ign_idle", 64'(bus.busy), 64'(0));
        bus.in_valid = 1'b1;
        tick();
        bus.in_valid = 1'b0;
        tick();
        check("idle_beat_out", bus.out, e6);
        check("idle_busy", 64'(bus.busy), 64'(0));

        tick();
        check("sb_empty", 64'(sb.size()), 64'(0));
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
